touch_pwm_tracker: RTL and testbench

Multi-channel touch-to-brightness tracker: converts periodic touch-controller samples into per-channel PWM outputs with IIR smoothing, a hold-after-release period, and a linear fade-out. It sits between the FT6206 touch controller sample path and the board LEDs or pmod. It replaces direct coordinate-to-duty wiring in top-level designs.

---
 rtl/touch_pwm_tracker.sv | 194 +++++++++++++++++++
 tb/tb_touch_pwm_tracker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_pwm_tracker.sv
// rtl/touch_pwm_tracker.sv - touch samples to smoothed, held and faded per-channel PWM brightness
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   ena           global enable; low freezes every register
//   sample        one-cycle strobe marking a new valid/coords pair
//   valid         touch present in this sample
//   coords        channel i coordinate at [i*COORD_W +: COORD_W]
//   tick          hold/fade time-base strobe
//   pwm_step      PWM counter advance strobe
//   duty          working duty per channel, same packing as coords (DUTY_W per lane)
//   pwm_out       registered PWM output per channel
//   state         0 IDLE, 1 TRACK, 2 HOLD, 3 FADE
module touch_pwm_tracker #(
    parameter int NUM_CH      = 2,
    parameter int COORD_W     = 10,
    parameter int DUTY_W      = 12,
    parameter int ALPHA_SHIFT = 2,
    parameter int HOLD_TICKS  = 3,
    parameter int FADE_STEP   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        sample,
    input  logic                        valid,
    input  logic [NUM_CH*COORD_W-1:0]   coords,
    input  logic                        tick,
    input  logic                        pwm_step,
    output logic [NUM_CH*DUTY_W-1:0]    duty,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic [1:0]                  state
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [DUTY_W-1:0] FADE_V    = DUTY_W'(FADE_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2,
        S_FADE  = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [HOLD_W-1:0]                hold_cnt_q, hold_cnt_d;
    logic [NUM_CH-1:0][DUTY_W-1:0]    duty_q, duty_d;
    logic [NUM_CH-1:0][DUTY_W-1:0]    shadow_q, shadow_d;
    logic [DUTY_W-1:0]                cnt_q, cnt_d;
    logic [NUM_CH-1:0]                pwm_q, pwm_d;

    logic [NUM_CH-1:0][DUTY_W-1:0]    target;
    logic [NUM_CH-1:0][DUTY_W-1:0]    smooth_v;
    logic [NUM_CH-1:0][DUTY_W-1:0]    fade_v;
    logic                             take_sample;

    // Coordinate to duty scale: keep the MSBs when the coordinate is wider,
    // otherwise left-justify it into the duty range.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_target
        if (COORD_W >= DUTY_W) begin : g_trunc
            assign target[i] = coords[i*COORD_W + (COORD_W - DUTY_W) +: DUTY_W];
        end else begin : g_shift
            assign target[i] = {coords[i*COORD_W +: COORD_W], {(DUTY_W - COORD_W){1'b0}}};
        end
    end

    // IIR step toward the target. A step that would truncate to zero is
    // forced to +/-1 so the duty always reaches the target exactly.
    function automatic logic [DUTY_W-1:0] smooth_step(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic signed [DUTY_W:0]   diff;
        logic signed [DUTY_W:0]   step;
        logic signed [DUTY_W+1:0] sum;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = diff >>> ALPHA_SHIFT;
        if (step == '0 && diff != '0) begin
            step = diff[DUTY_W] ? '1 : {{DUTY_W{1'b0}}, 1'b1};
        end
        sum = $signed({2'b00, cur}) + $signed({step[DUTY_W], step});
        if (sum[DUTY_W+1]) begin
            smooth_step = '0;
        end else if (sum[DUTY_W]) begin
            smooth_step = '1;
        end else begin
            smooth_step = sum[DUTY_W-1:0];
        end
    endfunction

    always_comb begin
        smooth_v = '0;
        fade_v   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            smooth_v[i] = smooth_step(duty_q[i], target[i]);
            fade_v[i]   = (duty_q[i] > FADE_V) ? duty_q[i] - FADE_V : '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            duty_q     <= '0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            duty_q     <= duty_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    // Next-state and duty datapath. A valid sample always wins over a tick
    // arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        duty_d      = duty_q;
        take_sample = sample & valid;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (take_sample) begin
                        state_d = S_TRACK;
                        duty_d  = target;
                    end
                end
                S_TRACK: begin
                    if (take_sample) begin
                        duty_d = smooth_v;
                    end else if (sample) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    if (take_sample) begin
                        state_d = S_TRACK;
                        duty_d  = smooth_v;
                    end else if (tick) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d = S_FADE;
                        end
                    end
                end
                S_FADE: begin
                    if (take_sample) begin
                        state_d = S_TRACK;
                        duty_d  = smooth_v;
                    end else if (tick) begin
                        duty_d = fade_v;
                        if (fade_v == '0) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // PWM: shared counter; shadows reload only at the period wrap so a duty
    // change never truncates or stretches the pulse in progress.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        pwm_d    = pwm_q;
        if (ena) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_d[i] = (cnt_q < shadow_q[i]);
            end
            if (pwm_step) begin
                cnt_d = cnt_q + DUTY_W'(1);
                if (cnt_q == '1) begin
                    shadow_d = duty_q;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        duty    = duty_q;
        pwm_out = pwm_q;
        state   = state_q;
    end

endmodule

// File: tb/tb_touch_pwm_tracker.sv
// tb/tb_touch_pwm_tracker.sv - randomized and directed bench for touch_pwm_tracker
module tb_touch_pwm_tracker;

    localparam int NCH   = 2;
    localparam int CW    = 10;
    localparam int DW    = 12;
    localparam int DMAX  = (1 << DW) - 1;
    localparam int ALPHA = 2;
    localparam int HOLDT = 3;
    localparam int FSTEP = 256;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, ena, sample, valid, tick, pwm_step;
    logic [NCH*CW-1:0] coords;
    logic [NCH*DW-1:0] duty;
    logic [NCH-1:0]    pwm_out;
    logic [1:0]        state;

    touch_pwm_tracker #(
        .NUM_CH(NCH), .COORD_W(CW), .DUTY_W(DW),
        .ALPHA_SHIFT(ALPHA), .HOLD_TICKS(HOLDT), .FADE_STEP(FSTEP)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .sample(sample), .valid(valid),
        .coords(coords), .tick(tick), .pwm_step(pwm_step),
        .duty(duty), .pwm_out(pwm_out), .state(state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules in plain integer arithmetic.
    int m_duty[NCH];
    int m_shadow[NCH];
    int m_pwm[NCH];
    int m_state, m_ticks, m_cnt;

    function automatic int floor_div(input int a, input int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    function automatic int smooth_model(input int cur, input int tgt);
        int diff, st, nv;
        diff = tgt - cur;
        st   = floor_div(diff, 1 << ALPHA);
        if (st == 0 && diff != 0) st = (diff > 0) ? 1 : -1;
        nv = cur + st;
        if (nv < 0) nv = 0;
        if (nv > DMAX) nv = DMAX;
        return nv;
    endfunction

    function automatic int coord_of(input int ch);
        return int'(coords[ch*CW +: CW]);
    endfunction

    always @(posedge clk) begin
        int nd[NCH];
        bit all_zero;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_duty[i] = 0; m_shadow[i] = 0; m_pwm[i] = 0;
            end
            m_state = 0; m_ticks = 0; m_cnt = 0;
        end else if (ena) begin
            for (int i = 0; i < NCH; i++) m_pwm[i] = (m_cnt < m_shadow[i]) ? 1 : 0;
            if (pwm_step) begin
                if (m_cnt == DMAX) for (int i = 0; i < NCH; i++) m_shadow[i] = m_duty[i];
                m_cnt = (m_cnt + 1) % (DMAX + 1);
            end
            if (sample && valid) begin
                for (int i = 0; i < NCH; i++) begin
                    if (m_state == 0) m_duty[i] = coord_of(i) * (1 << (DW - CW));
                    else m_duty[i] = smooth_model(m_duty[i], coord_of(i) * (1 << (DW - CW)));
                end
                m_state = 1;
            end else if (sample && m_state == 1) begin
                m_state = 2;
                m_ticks = 0;
            end else if (tick && m_state == 2) begin
                m_ticks++;
                if (m_ticks == HOLDT) m_state = 3;
            end else if (tick && m_state == 3) begin
                all_zero = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    nd[i] = (m_duty[i] - FSTEP < 0) ? 0 : m_duty[i] - FSTEP;
                    m_duty[i] = nd[i];
                    if (nd[i] != 0) all_zero = 1'b0;
                end
                if (all_zero) m_state = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("cyc_duty%0d", i), 32'(duty[i*DW +: DW]), 32'(m_duty[i]));
                check($sformatf("cyc_pwm%0d", i), 32'(pwm_out[i]), 32'(m_pwm[i]));
            end
            check("cyc_state", 32'(state), 32'(m_state));
        end
    end

    task automatic drive_cycle(input bit s, input bit v, input int c0, input int c1, input bit t);
        sample = s;
        valid  = v;
        coords = {CW'(c1), CW'(c0)};
        tick   = t;
        @(posedge clk);
        #1;
        sample = 1'b0;
        tick   = 1'b0;
    endtask

    function automatic int duty_of(input int ch);
        return int'(duty[ch*DW +: DW]);
    endfunction

    int exp_d0[5] = '{244, 0, 0, 0, 0};
    int exp_d1[5] = '{944, 688, 432, 176, 0};
    int exp_st[5] = '{3, 3, 3, 3, 0};

    initial begin
        int hi0, hi1;
        bit aligned;
        rst = 1'b1; ena = 1'b1; sample = 1'b0; valid = 1'b0;
        tick = 1'b0; pwm_step = 1'b0; coords = '0;
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_duty", 32'(duty), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_pwm", 32'(pwm_out), 32'd0);

        // Direct load from IDLE
        drive_cycle(1, 1, 100, 300, 0);
        check("load_duty0", duty_of(0), 400);
        check("load_duty1", duty_of(1), 1200);
        check("load_state", 32'(state), 1);

        // Smoothed update
        drive_cycle(1, 1, 200, 300, 0);
        check("smooth_duty0", duty_of(0), 500);
        check("smooth_duty1", duty_of(1), 1200);

        // Release, hold, fade to IDLE
        drive_cycle(1, 0, 0, 0, 0);
        check("hold_state", 32'(state), 2);
        drive_cycle(1, 0, 0, 0, 0);
        check("hold_no_restart", 32'(state), 2);
        for (int k = 0; k < HOLDT; k++) drive_cycle(0, 0, 0, 0, 1);
        check("fade_state", 32'(state), 3);
        check("fade_hold_duty0", duty_of(0), 500);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(0, 0, 0, 0, 1);
            check($sformatf("fade%0d_duty0", k), duty_of(0), exp_d0[k]);
            check($sformatf("fade%0d_duty1", k), duty_of(1), exp_d1[k]);
            check($sformatf("fade%0d_state", k), 32'(state), exp_st[k]);
        end

        // Sample during HOLD together with a tick
        drive_cycle(1, 1, 100, 300, 0);
        drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(1, 1, 100, 300, 1);
        check("hold_resume_state", 32'(state), 1);
        check("hold_resume_duty0", duty_of(0), 400);
        check("hold_resume_duty1", duty_of(1), 1200);

        // Sample and tick together in FADE
        drive_cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < HOLDT; k++) drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1);
        check("fade1_duty0", duty_of(0), 144);
        drive_cycle(1, 1, 100, 300, 1);
        check("simul_duty0", duty_of(0), 208);
        check("simul_duty1", duty_of(1), 1008);
        check("simul_state", 32'(state), 1);

        // Convergence and unit steps
        for (int k = 0; k < 40; k++) drive_cycle(1, 1, 200, 300, 0);
        check("conv_duty0", duty_of(0), 800);
        check("conv_duty1", duty_of(1), 1200);
        drive_cycle(1, 1, 201, 300, 0);
        drive_cycle(1, 1, 201, 300, 0);
        check("unit_step_a", duty_of(0), 802);
        drive_cycle(1, 1, 201, 300, 0);
        drive_cycle(1, 1, 201, 300, 0);
        check("unit_step_b", duty_of(0), 804);

        // PWM period accounting with a mid-period duty change
        for (int k = 0; k < 40; k++) drive_cycle(1, 1, 256, 300, 0);
        check("pwm_setup_duty0", duty_of(0), 1024);
        pwm_step = 1'b1;
        aligned = 1'b0;
        for (int k = 0; k < 5000 && !aligned; k++) begin
            drive_cycle(0, 0, 0, 0, 0);
            if (m_cnt == 0) aligned = 1'b1;
        end
        check("pwm_align", 32'(aligned), 1);
        hi0 = 0; hi1 = 0;
        for (int k = 0; k < 4096; k++) begin
            drive_cycle((k >= 2000 && k < 2060), 1'b1, 512, 300, 0);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
        end
        check("pwm_win1_ch0", hi0, 1024);
        check("pwm_win1_ch1", hi1, 1200);
        check("pwm_changed_duty0", duty_of(0), 2048);
        hi0 = 0; hi1 = 0;
        for (int k = 0; k < 4096; k++) begin
            drive_cycle(0, 0, 0, 0, 0);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
        end
        check("pwm_win2_ch0", hi0, 2048);
        check("pwm_win2_ch1", hi1, 1200);

        // Global freeze
        ena = 1'b0;
        for (int k = 0; k < 100; k++) begin
            pwm_step = 1'(k);
            drive_cycle(1'(k >> 1), 1'(k >> 2), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'(k >> 3));
        end
        check("ena0_duty0", duty_of(0), 2048);
        check("ena0_duty1", duty_of(1), 1200);
        check("ena0_state", 32'(state), 1);
        ena = 1'b1;
        pwm_step = 1'b0;

        // Reset while fading
        drive_cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < HOLDT + 1; k++) drive_cycle(0, 0, 0, 0, 1);
        check("pre_rst_state", 32'(state), 3);
        rst = 1'b1;
        drive_cycle(0, 0, 0, 0, 1);
        rst = 1'b0;
        check("rst_fade_duty", 32'(duty), 0);
        check("rst_fade_pwm", 32'(pwm_out), 0);
        check("rst_fade_state", 32'(state), 0);

        // Randomized traffic, alternating busy and sparse sample phases
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 499) == 0);
            ena      = ($urandom_range(0, 9) != 0);
            pwm_step = 1'($urandom_range(0, 1));
            drive_cycle(((k / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0),
                        ($urandom_range(0, 2) != 0),
                        $urandom_range(0, 1023), $urandom_range(0, 1023),
                        ($urandom_range(0, 3) == 0));
        end
        rst = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
